// File: rtl/lfsr_mem_pkg.sv
// Shared definitions for the LFSR-addressed associative memory (writer and search side).
package lfsr_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int MAX_WORDS = 255;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form (bits 7,5,4,3)
  localparam logic [ADDR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DONE,
    VERIFY_RD,
    VERIFY_CMP
  } wr_state_t;

  // One LFSR step; both memory ends must use this so they walk the same address order
  function automatic logic [ADDR_W-1:0] lfsr_next(input logic [ADDR_W-1:0] q);
    return {q[ADDR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_mem_writer_if.sv
// Data stream and memory write port of the LFSR memory writer.
// The read-back pair Mem_RE/Mem_Rdata exists only when WR_VERIFY_EN is defined.
interface lfsr_mem_writer_if;
  import lfsr_mem_pkg::*;

  logic [DATA_W-1:0] Data_in;
  logic              Data_Valid;
  logic              Data_Ready;
  logic              Mem_WE;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data;
`ifdef WR_VERIFY_EN
  logic              Mem_RE;
  logic [DATA_W-1:0] Mem_Rdata;
`endif

  // Writer's view: consumes the stream, drives the memory port
  modport master (
    input  Data_in, Data_Valid,
    output Data_Ready, Mem_WE, Mem_Addr, Mem_Data
`ifdef WR_VERIFY_EN
    , output Mem_RE
    , input  Mem_Rdata
`endif
  );

  // Host/memory view
  modport slave (
    output Data_in, Data_Valid,
    input  Data_Ready, Mem_WE, Mem_Addr, Mem_Data
`ifdef WR_VERIFY_EN
    , input  Mem_RE
    , output Mem_Rdata
`endif
  );

endinterface

// File: rtl/lfsr8_step.sv
// Registered 8-bit maximal-length LFSR with seed load and advance enables.
// Shared with the search side so both generate the identical address sequence.
module lfsr8_step
  import lfsr_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SEED = 8'h01
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] q
);

  // Load has priority so a fresh start always begins at SEED
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lfsr_mem_writer.sv
// Write-side loader for the LFSR-addressed associative memory.
// Accepts WR_Count words over a valid/ready stream and writes each one to the
// address given by the LFSR, in the same order the search side walks.
// Optional read-back verify of every word: define WR_VERIFY_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for WR_Ext; illegal counts go straight to DONE
// LOAD       | Data_Ready high, one word accepted per valid cycle
// VERIFY_RD  | write strobe out, read-back issued on the same address
// VERIFY_CMP | read data compared against the written word
// DONE       | one-cycle WR_Done pulse, then back to IDLE
module lfsr_mem_writer #(
  parameter logic [7:0] SEED      = 8'h01,
  parameter int         MAX_WORDS = 255
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      WR_Ext,
  input  logic [15:0]               WR_Count,
  lfsr_mem_writer_if.master         bus,
  output logic                      WR_Busy,
  output logic                      WR_Done,
  output logic                      WR_Error
);
  import lfsr_mem_pkg::*;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  wr_state_t         state;
  logic [7:0]        cap_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_nxt;
  logic [ADDR_W-1:0] lfsr_q;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic              start_ok;
  logic              xfer;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  lfsr8_step #(.SEED(SEED)) u_lfsr (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  // Start qualification, transfer detect and LFSR control
  always_comb begin
    start_ok  = (WR_Count != 16'd0) && (WR_Count <= MAX_CNT);
    xfer      = (state == LOAD) && bus.Data_Valid;
    cnt_nxt   = cnt_q + 8'd1;
    lfsr_load = (state == IDLE) && WR_Ext && start_ok;
    lfsr_adv  = xfer;
  end

  // State-decoded status and registered memory port outputs
  always_comb begin
    bus.Data_Ready = (state == LOAD);
    WR_Busy        = (state == LOAD);
`ifdef WR_VERIFY_EN
    if ((state == VERIFY_RD) || (state == VERIFY_CMP)) WR_Busy = 1'b1;
    bus.Mem_RE     = (state == VERIFY_RD);
`endif
    WR_Done        = (state == DONE);
    WR_Error       = err_q;
    bus.Mem_WE     = we_q;
    bus.Mem_Addr   = addr_q;
    bus.Mem_Data   = data_q;
  end

  // Load sequencer: capture count, issue one write per accepted word, flag errors
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      cap_q  <= 8'd0;
      cnt_q  <= 8'd0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (WR_Ext) begin
            if (start_ok) begin
              cap_q <= WR_Count[7:0];
              cnt_q <= 8'd0;
              err_q <= 1'b0;
              state <= LOAD;
            end else begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            we_q   <= 1'b1;
            addr_q <= lfsr_q;
            data_q <= bus.Data_in;
            cnt_q  <= cnt_nxt;
`ifdef WR_VERIFY_EN
            state  <= VERIFY_RD;
`else
            if (cnt_nxt == cap_q) state <= DONE;
`endif
          end
        end
`ifdef WR_VERIFY_EN
        VERIFY_RD: begin
          state <= VERIFY_CMP;
        end
        VERIFY_CMP: begin
          if (bus.Mem_Rdata != data_q) err_q <= 1'b1;
          state <= (cnt_q == cap_q) ? DONE : LOAD;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_mem_writer.sv
// Directed bench for lfsr_mem_writer; expected addresses/data are hand-derived.
module tb_lfsr_mem_writer;

  logic        Clock    = 1'b0;
  logic        Reset_n  = 1'b0;
  logic        WR_Ext   = 1'b0;
  logic [15:0] WR_Count = 16'd0;
  logic        WR_Busy;
  logic        WR_Done;
  logic        WR_Error;

  int vectors     = 0;
  int miscompares = 0;

  lfsr_mem_writer_if bus();

  lfsr_mem_writer #(.SEED(8'h01), .MAX_WORDS(255)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .WR_Ext   (WR_Ext),
    .WR_Count (WR_Count),
    .bus      (bus),
    .WR_Busy  (WR_Busy),
    .WR_Done  (WR_Done),
    .WR_Error (WR_Error)
  );

  always #5 Clock = ~Clock;

  // Write monitor sampled on the falling edge
  int         we_cnt   = 0;
  int         done_cnt = 0;
  int         done_we  = 0;
  logic [7:0] addr_q[$];
  logic [7:0] data_q[$];
  logic       err_at_we[$];

  always @(negedge Clock) begin
    if (bus.Mem_WE === 1'b1) begin
      we_cnt++;
      addr_q.push_back(bus.Mem_Addr);
      data_q.push_back(bus.Mem_Data);
      err_at_we.push_back(WR_Error);
    end
    if (WR_Done === 1'b1) begin
      done_cnt++;
      if (bus.Mem_WE === 1'b1) done_we++;
    end
  end

`ifdef WR_VERIFY_EN
  // Memory model that corrupts whatever is written to address 04; write-first read
  logic [7:0] mem [256];
  always @(posedge Clock) begin
    if (bus.Mem_WE) mem[bus.Mem_Addr] <= (bus.Mem_Addr == 8'h04) ? ~bus.Mem_Data : bus.Mem_Data;
    if (bus.Mem_RE) bus.Mem_Rdata <= bus.Mem_WE ?
        ((bus.Mem_Addr == 8'h04) ? ~bus.Mem_Data : bus.Mem_Data) : mem[bus.Mem_Addr];
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_mon();
    we_cnt = 0;
    done_cnt = 0;
    done_we = 0;
    addr_q.delete();
    data_q.delete();
    err_at_we.delete();
  endtask

  task automatic start(input logic [15:0] cnt);
    WR_Count = cnt;
    WR_Ext   = 1'b1;
    step();
    WR_Ext   = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp_a [5];
    logic [7:0]  exp_b [5];
    logic [4:0]  pat;
    logic [15:0] bad [2];
    logic [7:0]  mq;
    logic [7:0]  last;
    logic [7:0]  nxt;
    logic        seen [256];
    int          dup;
    int          zero;
    int          amis;
    int          dmis;

    exp_a = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    exp_b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
    pat   = 5'b10101;
    bad   = '{16'h0000, 16'h0100};

    bus.Data_in    = 8'h00;
    bus.Data_Valid = 1'b0;

    // Reset state
    #12;
    chk("rst_we",    32'(bus.Mem_WE),     32'h0);
    chk("rst_addr",  32'(bus.Mem_Addr),   32'h0);
    chk("rst_data",  32'(bus.Mem_Data),   32'h0);
    chk("rst_busy",  32'(WR_Busy),        32'h0);
    chk("rst_done",  32'(WR_Done),        32'h0);
    chk("rst_err",   32'(WR_Error),       32'h0);
    chk("rst_ready", 32'(bus.Data_Ready), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    step();

`ifdef WR_VERIFY_EN
    begin
      int n;
      int cyc;
      logic acc;
      clear_mon();
      start(16'd5);
      n = 0;
      cyc = 0;
      while (WR_Done !== 1'b1 && cyc < 60) begin
        bus.Data_Valid = (n < 5);
        bus.Data_in    = 8'(8'hA0 + n);
        acc = bus.Data_Ready && bus.Data_Valid;
        step();
        if (acc) n++;
        cyc++;
      end
      chk("vfy_in_time", 32'(cyc < 60), 32'h1);
      bus.Data_Valid = 1'b0;
      step();
      chk("vfy_writes", 32'(we_cnt), 32'd5);
      chk("vfy_err", 32'(WR_Error), 32'h1);
      chk("vfy_done", 32'(done_cnt), 32'd1);
      if (err_at_we.size() == 5) begin
        chk("vfy_err_before3", 32'(err_at_we[2]), 32'h0);
        chk("vfy_err_after3",  32'(err_at_we[3]), 32'h1);
      end
    end
`else
    // Five words back to back
    clear_mon();
    start(16'd5);
    chk("a_busy",  32'(WR_Busy),        32'h1);
    chk("a_ready", 32'(bus.Data_Ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      bus.Data_Valid = 1'b1;
      bus.Data_in    = 8'(8'hA0 + i);
      step();
      chk("a_we",   32'(bus.Mem_WE),   32'h1);
      chk("a_addr", 32'(bus.Mem_Addr), 32'(exp_a[i]));
      chk("a_data", 32'(bus.Mem_Data), 32'(8'hA0 + i));
      chk("a_done", 32'(WR_Done),      32'(i == 4));
    end
    chk("a_busy_end", 32'(WR_Busy), 32'h0);
    bus.Data_Valid = 1'b0;
    step();
    chk("a_we_off",    32'(bus.Mem_WE),   32'h0);
    chk("a_done_off",  32'(WR_Done),      32'h0);
    chk("a_addr_hold", 32'(bus.Mem_Addr), 32'h11);
    chk("a_data_hold", 32'(bus.Mem_Data), 32'hA4);
    chk("a_done_with_we", 32'(done_we), 32'd1);

    // Three words, valid toggling; WR_Ext and WR_Count disturbed mid-load
    clear_mon();
    start(16'd3);
    for (int k = 0; k < 5; k++) begin
      bus.Data_Valid = pat[k];
      bus.Data_in    = 8'(8'hB0 + k);
      if (k == 1) begin
        WR_Ext   = 1'b1;
        WR_Count = 16'd1;
      end else begin
        WR_Ext   = 1'b0;
      end
      step();
      chk("b_we", 32'(bus.Mem_WE), 32'(pat[k]));
      if (pat[k]) begin
        chk("b_addr", 32'(bus.Mem_Addr), 32'(exp_b[k]));
        chk("b_data", 32'(bus.Mem_Data), 32'(8'hB0 + k));
      end
      chk("b_done", 32'(WR_Done), 32'(k == 4));
    end
    bus.Data_Valid = 1'b0;
    step();
    chk("b_writes", 32'(we_cnt), 32'd3);

    // Illegal counts: error, quick done, no writes
    clear_mon();
    for (int j = 0; j < 2; j++) begin
      start(bad[j]);
      chk("c_err",   32'(WR_Error), 32'h1);
      chk("c_done",  32'(WR_Done),  32'h1);
      chk("c_ready", 32'(bus.Data_Ready), 32'h0);
      step();
      chk("c_done_off", 32'(WR_Done),  32'h0);
      chk("c_err_stick", 32'(WR_Error), 32'h1);
    end
    chk("c_no_writes", 32'(we_cnt), 32'd0);
    start(16'd1);
    chk("c_err_clear", 32'(WR_Error), 32'h0);
    bus.Data_Valid = 1'b1;
    bus.Data_in    = 8'h5A;
    step();
    chk("c_addr", 32'(bus.Mem_Addr), 32'h01);
    chk("c_done1", 32'(WR_Done), 32'h1);
    bus.Data_Valid = 1'b0;
    step();

    // Full period: 255 distinct nonzero addresses in LFSR order
    clear_mon();
    start(16'd255);
    for (int i = 0; i < 255; i++) begin
      bus.Data_Valid = 1'b1;
      bus.Data_in    = 8'(i);
      step();
    end
    chk("d_done", 32'(WR_Done), 32'h1);
    bus.Data_Valid = 1'b0;
    step();
    chk("d_writes", 32'(we_cnt), 32'd255);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    dup = 0; zero = 0; amis = 0; dmis = 0;
    mq = 8'h01;
    for (int i = 0; i < addr_q.size(); i++) begin
      if (seen[addr_q[i]]) dup++;
      seen[addr_q[i]] = 1'b1;
      if (addr_q[i] == 8'h00) zero++;
      if (addr_q[i] !== mq) amis++;
      if (data_q[i] !== 8'(i)) dmis++;
      mq = {mq[6:0], mq[7] ^ mq[5] ^ mq[4] ^ mq[3]};
    end
    chk("d_dups",  32'(dup),  32'd0);
    chk("d_zero",  32'(zero), 32'd0);
    chk("d_order", 32'(amis), 32'd0);
    chk("d_data",  32'(dmis), 32'd0);
    last = (addr_q.size() == 255) ? addr_q[254] : 8'h00;
    nxt  = {last[6:0], last[7] ^ last[5] ^ last[4] ^ last[3]};
    chk("d_wrap", 32'(nxt), 32'h01);
    chk("d_first_seen00", 32'(seen[0]), 32'h0);

    // Reset after the second write of a five-word load
    clear_mon();
    start(16'd5);
    bus.Data_Valid = 1'b1;
    bus.Data_in    = 8'hC0;
    step();
    bus.Data_in    = 8'hC1;
    step();
    chk("e_addr2", 32'(bus.Mem_Addr), 32'h02);
    @(negedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("e_we_rst",   32'(bus.Mem_WE),   32'h0);
    chk("e_addr_rst", 32'(bus.Mem_Addr), 32'h0);
    chk("e_data_rst", 32'(bus.Mem_Data), 32'h0);
    chk("e_busy_rst", 32'(WR_Busy),      32'h0);
    step();
    step();
    @(negedge Clock);
    Reset_n = 1'b1;
    step();
    step();
    chk("e_no_more_we", 32'(we_cnt), 32'd2);
    bus.Data_Valid = 1'b0;
    start(16'd2);
    bus.Data_Valid = 1'b1;
    bus.Data_in    = 8'hD0;
    step();
    chk("e_fresh_addr", 32'(bus.Mem_Addr), 32'h01);
    chk("e_fresh_data", 32'(bus.Mem_Data), 32'hD0);
    bus.Data_in    = 8'hD1;
    step();
    chk("e_fresh_addr2", 32'(bus.Mem_Addr), 32'h02);
    chk("e_fresh_done",  32'(WR_Done),      32'h1);
    bus.Data_Valid = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_mem_writer.md
Name: lfsr_mem_writer

Overview:
Write-side loader for the LFSR-addressed associative memory. It accepts a stream of 8-bit words over a valid/ready handshake and writes each word to the memory array. Write addresses come from a maximal-length 8-bit LFSR, in the same sequence the search side walks. It is the writer counterpart to the search/compare path and sits between the host data source and the memory array write port.

Parameters:
SEED, 8'h01, LFSR start value on each load. Must be nonzero; zero is illegal.
MAX_WORDS, 255, maximum legal WR_Count (LFSR period).

Ports:
Clock  in  1  single system clock, rising edge.
Reset_n  in  1  asynchronous active-low reset.
WR_Ext  in  1  start-load request, sampled in IDLE only.
WR_Count  in  16  number of words to write, captured at start.
Data_in  in  8  write data word.
Data_Valid  in  1  Data_in valid.
Data_Ready  out  1  writer accepts Data_in this cycle.
Mem_WE  out  1  memory write strobe, one-cycle pulse per word.
Mem_Addr  out  8  memory address (LFSR value).
Mem_Data  out  8  memory write data.
WR_Busy  out  1  load in progress.
WR_Done  out  1  one-cycle pulse at end of load.
WR_Error  out  1  sticky error; cleared on the next accepted start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; LFSR=SEED; word counter=0; all outputs 0, including Mem_Addr and Mem_Data.
- LFSR: Fibonacci, shift left, next = {q[6:0], q[7]^q[5]^q[4]^q[3]}. Polynomial x^8+x^6+x^5+x^4+1, period 255, never reaches 0. From 8'h01 the sequence is 01,02,04,08,11,23,...
- States: IDLE, LOAD, DONE (plus VERIFY_RD and VERIFY_CMP when the feature is on).
- IDLE: WR_Ext=1 at a rising edge:
  - If WR_Count is 0 or greater than MAX_WORDS: WR_Error=1, go to DONE. No writes are issued.
  - Otherwise: capture WR_Count, LFSR=SEED, WR_Error=0, go to LOAD.
- LOAD: WR_Busy=1 and Data_Ready=1, both combinational on state.
  - A transfer occurs on an edge where Data_Valid & Data_Ready.
  - Next cycle: Mem_WE=1, Mem_Addr=pre-advance LFSR, Mem_Data=Data_in. Registered outputs, latency 1.
  - On the same edge the LFSR advances and the counter increments.
  - When the counter reaches the captured count, go to DONE. The final write pulse coincides with the DONE cycle.
  - Throughput: one word per cycle.
- DONE: WR_Done=1 for exactly one cycle, WR_Busy=0, Data_Ready=0, then IDLE.
- Mem_Addr and Mem_Data hold their last value when Mem_WE=0.
- WR_Ext during LOAD or DONE is ignored; no restart or abort.
- WR_Ext held high across DONE→IDLE starts a new load. The bench must pulse it.
- Data_Valid with Data_Ready=0 has no effect.
- WR_Count changes after capture have no effect.
- Reset mid-load: immediate return to IDLE. No further Mem_WE. Partial contents are left as-is.
- WR_Count=255: 255 distinct nonzero addresses. Address 00 is never written.

Optional Feature:
Macro WR_VERIFY_EN. When defined, the block adds:
- Ports: Mem_RE out 1, Mem_Rdata in 8.
- After each Mem_WE pulse:
  - VERIFY_RD: Mem_RE=1 on the same Mem_Addr.
  - VERIFY_CMP: compare Mem_Rdata with the latched word. On mismatch, WR_Error=1 (sticky). The load continues.
- Data_Ready=0 in both verify states, so throughput is one word per 3 cycles.
- WR_Done follows the last compare.

When not defined: the ports and verify states are absent, and throughput is one word per cycle.

Decomposition:
- Shared package lfsr_mem_pkg:
  - ADDR_W=8, DATA_W=8, LFSR_TAPS mask 8'hB8, MAX_WORDS.
  - State encoding typedef (IDLE, LOAD, DONE, VERIFY_RD, VERIFY_CMP).
- Sub-module lfsr8_step: registered LFSR with load(seed)/advance enables. Reused by the search side so both ends generate an identical address sequence.

Test Plan:
- WR_Count=5, Data 0xA0..0xA4 back-to-back valid:
  - Mem_WE on 5 consecutive cycles; addresses 01,02,04,08,11; data A0..A4.
  - WR_Done pulse one cycle, coincident with the last write.
- WR_Count=3, Data_Valid toggling 1,0,1,0,1 → writes only on valid cycles, addresses 01,02,04, no dropped or duplicated words.
- WR_Count=0, then WR_Count=16'h0100:
  - Each gives WR_Error=1, WR_Done after 1 cycle, zero Mem_WE.
  - The next legal start clears WR_Error.
- WR_Count=255, all valid:
  - 255 writes, all addresses distinct and nonzero.
  - After the load the LFSR is back at 01.
- Reset_n low after the 2nd write of WR_Count=5 → outputs 0 asynchronously, no further Mem_WE; a fresh start begins at address 01.
- WR_VERIFY_EN: memory model corrupts the word at address 04 → WR_Error=1 after the third compare, all words still written, WR_Done asserted.
